// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared opcodes, FSM state encodings and datapath control codes
// No ports; imported by ctrl_alu_decode and multicycle_control_unit.
package multicycle_pkg;
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;
  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JR    = 2'b10;
  localparam logic [1:0] PC_JMP   = 2'b11;
  localparam logic [1:0] RO_RA    = 2'b00;
  localparam logic [1:0] RO_RT    = 2'b01;
  localparam logic [1:0] RO_RD    = 2'b10;
  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_SHAMT = 2'b10;
endpackage

// File: rtl/ctrl_alu_decode.sv
// ctrl_alu_decode: opcode -> ALU controls for register/immediate ALU instructions
// In: op. Out: is_alu (op is an ALU instruction), alu_op, alu_src_b, ext_sel, reg_out.
module ctrl_alu_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] op,
  output logic       is_alu,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic [1:0] ext_sel,
  output logic [1:0] reg_out
);
  always_comb begin
    is_alu = 1'b1;
    alu_op = ALU_ADD;
    alu_src_b = 1'b0;
    ext_sel = EXT_ZERO;
    reg_out = RO_RD;
    case (op)
      OP_ADD: ;
      OP_SUB: alu_op = ALU_SUB;
      OP_ADDI: begin alu_src_b = 1'b1; ext_sel = EXT_SIGN; reg_out = RO_RT; end
      OP_OR: alu_op = ALU_OR;
      OP_AND: alu_op = ALU_AND;
      OP_ORI: begin alu_op = ALU_OR; alu_src_b = 1'b1; reg_out = RO_RT; end
      OP_SLL: begin alu_op = ALU_SLL; ext_sel = EXT_SHAMT; end
      OP_SLT: alu_op = ALU_SLT;
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_src_b = 1'b1; ext_sel = EXT_SIGN; reg_out = RO_RT; end
      default: begin is_alu = 1'b0; reg_out = RO_RA; end
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EXE/MEM/WB sequencer driving all multi-cycle CPU datapath controls
// In: clk, Reset (async active-low), opcode (IR[31:26]), zero (ALU flag).
// Out: PCWre, IRWre, InsMemRW, RegWre, RegOut, ALUSrcB, ALUM2Reg, DataMemRW, Extsel, PCSrc, ALUOp, state.
module multicycle_control_unit
  import multicycle_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           RegWre,
  output logic [1:0]     RegOut,
  output logic           ALUSrcB,
  output logic           ALUM2Reg,
  output logic           DataMemRW,
  output logic [1:0]     Extsel,
  output logic [1:0]     PCSrc,
  output logic [2:0]     ALUOp,
  output logic [2:0]     state
);
  logic [2:0] state_q, state_d;
  logic halt_q, halt_d;
  logic is_alu, dec_src_b;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_ext, dec_reg_out;
  ctrl_alu_decode u_dec (
    .op(opcode), .is_alu(is_alu), .alu_op(dec_alu_op),
    .alu_src_b(dec_src_b), .ext_sel(dec_ext), .reg_out(dec_reg_out)
  );
  logic is_beq, is_lw, is_sw, is_j, is_jr, is_jal, is_halt;
  assign is_beq = opcode == OP_BEQ;
  assign is_lw = opcode == OP_LW;
  assign is_sw = opcode == OP_SW;
  assign is_j = opcode == OP_J;
  assign is_jr = opcode == OP_JR;
  assign is_jal = opcode == OP_JAL;
  assign is_halt = opcode == OP_HALT;
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      state_q <= S_IF;
      halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q <= halt_d;
    end
  // Halt parks the FSM in ID with the halt flag set, so state reads 001 while frozen.
  always_comb begin
    halt_d = halt_q;
    state_d = S_IF;
    if (halt_q) state_d = state_q;
    else
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: begin
          state_d = is_alu ? S_EXE_AL : is_beq ? S_EXE_BR : (is_lw || is_sw) ? S_EXE_LS : is_halt ? S_ID : S_IF;
          halt_d = is_halt;
        end
        S_EXE_AL: state_d = S_WB_AL;
        S_EXE_LS: state_d = S_MEM;
        S_MEM: state_d = is_lw ? S_WB_LD : S_IF;
        default: state_d = S_IF;
      endcase
  end
  always_comb begin
    PCWre = 1'b0;
    IRWre = 1'b0;
    RegWre = 1'b0;
    RegOut = RO_RA;
    ALUSrcB = 1'b0;
    ALUM2Reg = 1'b0;
    DataMemRW = 1'b0;
    Extsel = EXT_ZERO;
    PCSrc = PC_SEQ;
    ALUOp = ALU_ADD;
    if (!halt_q)
      case (state_q)
        S_IF: IRWre = Reset;
        S_ID: begin
          // Anything not continuing to an EXE state (jumps and unknown opcodes) finishes here.
          PCWre = !(is_alu || is_beq || is_lw || is_sw || is_halt);
          PCSrc = (is_j || is_jal) ? PC_JMP : is_jr ? PC_JR : PC_SEQ;
          RegWre = is_jal;
        end
        S_EXE_AL: begin
          ALUOp = dec_alu_op;
          ALUSrcB = dec_src_b;
          Extsel = dec_ext;
        end
        S_WB_AL: begin
          RegWre = 1'b1;
          RegOut = dec_reg_out;
          PCWre = 1'b1;
        end
        S_EXE_BR: begin
          ALUOp = ALU_SUB;
          Extsel = EXT_SIGN;
          PCWre = 1'b1;
          PCSrc = zero ? PC_BR : PC_SEQ;
        end
        S_EXE_LS: begin
          ALUSrcB = 1'b1;
          Extsel = EXT_SIGN;
        end
        S_MEM: begin
          DataMemRW = is_sw;
          PCWre = is_sw;
        end
        S_WB_LD: begin
          RegWre = 1'b1;
          RegOut = RO_RT;
          ALUM2Reg = 1'b1;
          PCWre = 1'b1;
        end
        default: ;
      endcase
  end
  assign InsMemRW = 1'b1;
  assign state = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed instruction sequences checked against a per-instruction phase model
module tb_multicycle_control_unit;
  logic clk = 1'b0, Reset = 1'b0, zero = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic PCWre, IRWre, InsMemRW, RegWre, ALUSrcB, ALUM2Reg, DataMemRW;
  logic [1:0] RegOut, Extsel, PCSrc;
  logic [2:0] ALUOp, state;
  multicycle_control_unit #(.OPW(6)) dut (
    .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .RegOut(RegOut), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg), .DataMemRW(DataMemRW),
    .Extsel(Extsel), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
  );
  always #5 clk = ~clk;
  // Vector order: PCWre IRWre InsMemRW RegWre RegOut ALUSrcB ALUM2Reg DataMemRW Extsel PCSrc ALUOp state
  logic [18:0] got, exp_v;
  assign got = {PCWre, IRWre, InsMemRW, RegWre, RegOut, ALUSrcB, ALUM2Reg, DataMemRW, Extsel, PCSrc, ALUOp, state};
  localparam logic [18:0] RST_V = 19'b0_0_1_0_00_0_0_0_00_00_000_000;
  int tests = 0, fails = 0, cur_k = 0;
  logic chk = 1'b0;
  always @(negedge clk)
    if (chk) begin
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL cycle op=%b k=%0d: got=%b want=%b", opcode, cur_k, got, exp_v);
      end
    end
  // Instruction classes: 0 alu, 1 beq, 2 lw, 3 sw, 4 j/jr/jal, 5 unknown, 6 halt
  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b011000, 6'b100110, 6'b100111: return 0;
      6'b110100: return 1;
      6'b110001: return 2;
      6'b110000: return 3;
      6'b111000, 6'b111001, 6'b111010: return 4;
      6'b111111: return 6;
      default: return 5;
    endcase
  endfunction
  function automatic int lat(input logic [5:0] op);
    case (cls_of(op))
      0: return 4;
      1: return 3;
      2: return 5;
      3: return 4;
      6: return 22;
      default: return 2;
    endcase
  endfunction
  function automatic logic [18:0] model(input logic [5:0] op, input int k, input logic z);
    int c, len;
    logic fin, pcwre, regwre, srcb, m2r, dmw, imm;
    logic [1:0] regout, ext, pcsrc, aext;
    logic [2:0] aluop, aop, st;
    c = cls_of(op);
    len = lat(op);
    fin = (k == len - 1) && c != 6;
    imm = 1'b0;
    aop = 3'd0;
    aext = 2'b00;
    case (op)
      6'b000001: aop = 3'd1;
      6'b000010: begin imm = 1'b1; aext = 2'b01; end
      6'b010000: aop = 3'd3;
      6'b010001: aop = 3'd4;
      6'b010010: begin aop = 3'd3; imm = 1'b1; end
      6'b011000: begin aop = 3'd2; aext = 2'b10; end
      6'b100110: aop = 3'd6;
      6'b100111: begin aop = 3'd5; imm = 1'b1; aext = 2'b01; end
      default: ;
    endcase
    st = (k == 0) ? 3'b000 : (k == 1 || c == 6) ? 3'b001 :
         (c == 0) ? ((k == 2) ? 3'b110 : 3'b111) :
         (c == 1) ? 3'b101 : (k == 2) ? 3'b010 : (k == 3) ? 3'b011 : 3'b100;
    pcwre = fin;
    pcsrc = !fin ? 2'b00 : (op == 6'b111000 || op == 6'b111010) ? 2'b11 :
            (op == 6'b111001) ? 2'b10 : (c == 1 && z) ? 2'b01 : 2'b00;
    regwre = (fin && (c == 0 || c == 2)) || (op == 6'b111010 && k == 1);
    regout = (fin && c == 0) ? (imm ? 2'b01 : 2'b10) : (fin && c == 2) ? 2'b01 : 2'b00;
    m2r = fin && c == 2;
    dmw = fin && c == 3;
    srcb = 1'b0;
    ext = 2'b00;
    aluop = 3'd0;
    if (k == 2) begin
      if (c == 0) begin aluop = aop; srcb = imm; ext = aext; end
      if (c == 1) begin aluop = 3'd1; ext = 2'b01; end
      if (c == 2 || c == 3) begin srcb = 1'b1; ext = 2'b01; end
    end
    return {pcwre, k == 0, 1'b1, regwre, regout, srcb, m2r, dmw, ext, pcsrc, aluop, st};
  endfunction
  task automatic pin(input string name, input logic [18:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask
  task automatic run(input logic [5:0] op, input logic z, input int pk, input logic [18:0] pw, input string name);
    int len;
    len = lat(op);
    for (int k = 0; k < len; k++) begin
      opcode = op;
      zero = z;
      cur_k = k;
      exp_v = model(op, k, z);
      chk = 1'b1;
      if (k == pk) begin
        #2;
        pin(name, pw);
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    exp_v = RST_V;
    chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pin("reset_state", RST_V);
    Reset = 1'b1;
    run(6'b000000, 1'b0, 3, 19'b1_0_1_1_10_0_0_0_00_00_000_111, "add_wb");
    run(6'b000001, 1'b1, -1, '0, "");
    run(6'b000010, 1'b0, -1, '0, "");
    run(6'b010000, 1'b0, -1, '0, "");
    run(6'b010001, 1'b0, -1, '0, "");
    run(6'b010010, 1'b0, 2, 19'b0_0_1_0_00_1_0_0_00_00_011_110, "ori_exe");
    run(6'b011000, 1'b0, -1, '0, "");
    run(6'b100110, 1'b0, -1, '0, "");
    run(6'b100111, 1'b0, -1, '0, "");
    run(6'b110100, 1'b1, 2, 19'b1_0_1_0_00_0_0_0_01_01_001_101, "beq_taken");
    run(6'b110100, 1'b0, 2, 19'b1_0_1_0_00_0_0_0_01_00_001_101, "beq_not_taken");
    run(6'b110001, 1'b0, 4, 19'b1_0_1_1_01_0_1_0_00_00_000_100, "lw_wb");
    run(6'b110000, 1'b0, 3, 19'b1_0_1_0_00_0_0_1_00_00_000_011, "sw_mem");
    run(6'b111000, 1'b1, -1, '0, "");
    run(6'b111001, 1'b0, 1, 19'b1_0_1_0_00_0_0_0_00_10_000_001, "jr_id");
    run(6'b111010, 1'b0, 1, 19'b1_0_1_1_00_0_0_0_00_11_000_001, "jal_id");
    run(6'b000011, 1'b0, 1, 19'b1_0_1_0_00_0_0_0_00_00_000_001, "unknown_id");
    // Reset dropped asynchronously in the middle of an add's EXE_AL cycle.
    for (int k = 0; k < 3; k++) begin
      opcode = 6'b000000;
      cur_k = k;
      exp_v = model(6'b000000, k, 1'b0);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    pin("pre_reset_exe_al", 19'b0_0_1_0_00_0_0_0_00_00_000_110);
    exp_v = RST_V;
    Reset = 1'b0;
    #1;
    pin("reset_mid_exe", RST_V);
    @(posedge clk);
    #1;
    Reset = 1'b1;
    run(6'b000000, 1'b0, 0, 19'b0_1_1_0_00_0_0_0_00_00_000_000, "if_after_reset");
    run(6'b111111, 1'b0, 21, 19'b0_0_1_0_00_0_0_0_00_00_000_001, "halt_frozen");
    exp_v = RST_V;
    Reset = 1'b0;
    @(posedge clk);
    #1;
    Reset = 1'b1;
    run(6'b000000, 1'b0, 3, 19'b1_0_1_1_10_0_0_0_00_00_000_111, "add_after_halt");
    run(6'b111000, 1'b0, -1, '0, "");
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
